// File: rtl/tcm_stream_loader.sv
// tcm_stream_loader: packs a byte stream into little-endian words and writes them to one TCM port.
// Optional byte checksum on sum_o when LOADER_CHECKSUM_EN is defined.
module tcm_stream_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int N_ENTRIES  = 1024,
  parameter int LEN_WIDTH  = 16,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [AW-1:0]         base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  en_o,
  output logic                  we_o,
  output logic [NB-1:0]         be_o,
  output logic [AW-1:0]         addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [31:0]           sum_o
);
  localparam int LW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t                 state_q;
  logic [AW-1:0]          addr_q;
  logic [LEN_WIDTH-1:0]   rem_q;
  logic [LW-1:0]          lane_q;
  logic [NB-1:0]          be_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   busy_q, done_q, wr_q;
  logic                   last_byte;
  assign last_byte = lane_q == LW'(NB - 1) || rem_q == LEN_WIDTH'(1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wr_q   <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          addr_q  <= base_addr_i;
          rem_q   <= len_i;
          lane_q  <= '0;
          be_q    <= '0;
          data_q  <= '0;
          busy_q  <= 1'b1;
          done_q  <= len_i == '0;
          state_q <= len_i == '0 ? DONE : FILL;
        end
        FILL: if (byte_valid_i) begin
          data_q[8*lane_q +: 8] <= byte_i;
          be_q[lane_q]          <= 1'b1;
          lane_q                <= lane_q + LW'(1);
          rem_q                 <= rem_q - LEN_WIDTH'(1);
          wr_q                  <= last_byte;
          state_q               <= last_byte ? WRITE : FILL;
        end
        WRITE: begin
          lane_q  <= '0;
          be_q    <= '0;
          data_q  <= '0;
          addr_q  <= addr_q == AW'(N_ENTRIES - 1) ? '0 : addr_q + AW'(1);
          done_q  <= rem_q == '0;
          state_q <= rem_q == '0 ? DONE : FILL;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign byte_ready_o = state_q == FILL;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign en_o         = wr_q;
  assign we_o         = wr_q;
  assign be_o         = be_q;
  assign addr_o       = addr_q;
  assign data_o       = data_q;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) sum_q <= '0;
    else if (state_q == IDLE && start_i) sum_q <= '0;
    else if (state_q == FILL && byte_valid_i) sum_q <= sum_q + {24'b0, byte_i};
  end
  assign sum_o = sum_q;
`else
  assign sum_o = '0;
`endif
endmodule

// File: tb/tb_tcm_stream_loader.sv
// tb_tcm_stream_loader: table-driven directed vectors plus hand-written reset-mid-load sequence.
module tb_tcm_stream_loader;
  localparam int AW = 10;
  logic        clk_i = 1'b0;
  logic        rst_i, start_i, byte_valid_i;
  logic [AW-1:0] base_addr_i;
  logic [15:0] len_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o, busy_o, done_o, en_o, we_o;
  logic [3:0]  be_o;
  logic [AW-1:0] addr_o;
  logic [31:0] data_o, sum_o;
  int checks = 0;
  int failures = 0;
  always #5 clk_i = ~clk_i;
  tcm_stream_loader dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .busy_o(busy_o), .done_o(done_o), .en_o(en_o),
    .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .data_o(data_o), .sum_o(sum_o)
  );
  typedef struct {
    logic [AW-1:0] base;
    logic [15:0]   len;
    logic [63:0]   bytes;
    bit            gap;
    int            lat;
    int            nw;
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    logic [3:0]    be0;
    logic [AW-1:0] a1;
    logic [31:0]   d1;
    logic [3:0]    be1;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] exp_sum(input vec_t v);
    logic [31:0] s = '0;
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < int'(v.len); i++) s += {24'b0, v.bytes[8*i +: 8]};
`endif
    return s;
  endfunction
  task automatic run_vec(input vec_t v, input int k);
    int idx = 0, cyc = 0, busy_cnt = 0, nwr = 0;
    bit tog = 1'b1, seen_done = 1'b0;
    logic [AW-1:0] wa[2];
    logic [31:0] wd[2];
    logic [3:0] wb[2];
    logic [31:0] s_at_done = '0;
    @(negedge clk_i);
    base_addr_i = v.base;
    len_i = v.len;
    start_i = 1'b1;
    while (!seen_done && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      start_i = v.gap && cyc == 3;
      base_addr_i = v.gap ? 10'h3AA : v.base;
      len_i = v.gap ? 16'd0 : v.len;
      if (busy_o) busy_cnt++;
      if (en_o) begin
        chk($sformatf("v%0d we_o", k), we_o, 1'b1);
        chk($sformatf("v%0d ready_in_write", k), byte_ready_o, 1'b0);
        if (nwr < 2) begin
          wa[nwr] = addr_o;
          wd[nwr] = data_o;
          wb[nwr] = be_o;
        end
        nwr++;
      end
      if (done_o) begin
        seen_done = 1'b1;
        s_at_done = sum_o;
      end
      byte_valid_i = 1'b0;
      if (byte_ready_o && idx < int'(v.len)) begin
        if (!v.gap || tog) begin
          byte_valid_i = 1'b1;
          byte_i = v.bytes[8*idx +: 8];
          idx++;
        end
        tog = !tog;
      end
    end
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    chk($sformatf("v%0d done_seen", k), seen_done, 1'b1);
    if (v.lat > 0) chk($sformatf("v%0d latency", k), cyc, v.lat);
    chk($sformatf("v%0d busy_cycles", k), busy_cnt, cyc);
    chk($sformatf("v%0d nwrites", k), nwr, v.nw);
    if (v.nw > 0 && nwr > 0) begin
      chk($sformatf("v%0d addr0", k), wa[0], v.a0);
      chk($sformatf("v%0d data0", k), wd[0], v.d0);
      chk($sformatf("v%0d be0", k), wb[0], v.be0);
    end
    if (v.nw > 1 && nwr > 1) begin
      chk($sformatf("v%0d addr1", k), wa[1], v.a1);
      chk($sformatf("v%0d data1", k), wd[1], v.d1);
      chk($sformatf("v%0d be1", k), wb[1], v.be1);
    end
    chk($sformatf("v%0d sum", k), s_at_done, exp_sum(v));
    @(negedge clk_i);
    chk($sformatf("v%0d done_pulse", k), done_o, 1'b0);
    chk($sformatf("v%0d busy_clear", k), busy_o, 1'b0);
    chk($sformatf("v%0d sum_hold", k), sum_o, exp_sum(v));
  endtask
  initial begin
    int bad;
    vecs[0] = '{10'h010, 16'd8, 64'h8877665544332211, 1'b0, 11, 2,
                10'h010, 32'h44332211, 4'hF, 10'h011, 32'h88776655, 4'hF};
    vecs[1] = '{10'h020, 16'd6, 64'h0000A5A4A3A2A1A0, 1'b0, 9, 2,
                10'h020, 32'hA3A2A1A0, 4'hF, 10'h021, 32'h0000A5A4, 4'h3};
    vecs[2] = '{10'h3FF, 16'd8, 64'h0807060504030201, 1'b0, 11, 2,
                10'h3FF, 32'h04030201, 4'hF, 10'h000, 32'h08070605, 4'hF};
    vecs[3] = '{10'h055, 16'd0, 64'h0, 1'b0, 1, 0,
                10'h000, 32'h0, 4'h0, 10'h000, 32'h0, 4'h0};
    vecs[4] = '{10'h100, 16'd1, 64'h5A, 1'b0, 3, 1,
                10'h100, 32'h0000005A, 4'h1, 10'h000, 32'h0, 4'h0};
    vecs[5] = '{10'h010, 16'd8, 64'h8877665544332211, 1'b1, 0, 2,
                10'h010, 32'h44332211, 4'hF, 10'h011, 32'h88776655, 4'hF};
    vecs[6] = '{10'h200, 16'd4, 64'h0201FFFF, 1'b0, 6, 1,
                10'h200, 32'h0201FFFF, 4'hF, 10'h000, 32'h0, 4'h0};
    rst_i = 1'b1;
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_i = '0;
    base_addr_i = '0;
    len_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst ready", byte_ready_o, 1'b0);
    chk("rst busy", busy_o, 1'b0);
    chk("rst done", done_o, 1'b0);
    chk("rst en", en_o, 1'b0);
    chk("rst we", we_o, 1'b0);
    chk("rst be", be_o, 4'h0);
    chk("rst addr", addr_o, 10'h0);
    chk("rst data", data_o, 32'h0);
    chk("rst sum", sum_o, 32'h0);
    rst_i = 1'b0;
    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);
    // Reset after two bytes of a word: nothing may be written and no done pulse follows.
    @(negedge clk_i);
    base_addr_i = 10'h300;
    len_i = 16'd8;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("rm ready", byte_ready_o, 1'b1);
    byte_valid_i = 1'b1;
    byte_i = 8'hC1;
    @(negedge clk_i);
    byte_i = 8'hC2;
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rm ready_after", byte_ready_o, 1'b0);
    chk("rm busy_after", busy_o, 1'b0);
    bad = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (en_o || done_o || busy_o) bad++;
    end
    chk("rm quiet", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
